state_readout_vec4: RTL
=======================

STATE_READOUT_VEC4 -- requirements
Module: state_readout_vec4

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 4, lanes per beat.
REQ-002 SHALL have parameter W, default 16, lane width in bits (signed Q-format, passed through untouched).
REQ-003 SHALL have parameter S_ADDR_W, default 6, state RAM address width (depth 2^S_ADDR_W).
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port rd_len  in  S_ADDR_W+1  number of entries to read; 0 means 2^S_ADDR_W.
REQ-008 SHALL have port busy  out  1  high from accepted start until the last beat is accepted.
REQ-009 SHALL have port done  out  1  one-cycle pulse after the final beat is accepted.
REQ-010 SHALL have port mem_rd_en  out  1  state RAM read strobe.
REQ-011 SHALL have port mem_rd_addr  out  S_ADDR_W  state RAM read address.
REQ-012 SHALL have port mem_rd_data  in  TILE_SIZE x W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port m_valid  out  1  output beat valid.
REQ-014 SHALL have port m_ready  in  1  downstream ready.
REQ-015 SHALL have port m_vec  out  TILE_SIZE x W  output state vector.
REQ-016 SHALL have port m_last  out  1  marks the final beat of a sweep.

Function
REQ-017 SHALL use FSM IDLE -> RUN -> DRAIN -> IDLE: start in IDLE -> RUN; all reads issued -> DRAIN; final beat accepted -> IDLE with done=1 that cycle+1.
REQ-018 SHALL latch rd_len at start acceptance; changes on rd_len while busy SHALL be ignored.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL issue addresses 0,1,...,len-1 in order, one per mem_rd_en, never repeating or skipping.
REQ-021 SHALL hold a 2-entry output buffer; occupancy = buffered beats + reads in flight; mem_rd_en SHALL assert only in RUN when (occupancy - (m_valid&&m_ready)) < 2.
REQ-022 SHALL sustain one beat per cycle with m_ready held high; first m_valid 2 cycles after start.
REQ-023 SHALL follow AXI-stream rules: m_vec/m_last stable while m_valid=1 and m_ready=0; no beat lost or duplicated under arbitrary m_ready.
REQ-024 SHALL assert m_last only on the beat carrying address len-1; len=1 gives a single beat with m_last=1.
REQ-025 SHALL use an S_ADDR_W+1-bit issue counter so len=2^S_ADDR_W terminates without address wrap ambiguity.
REQ-026 SHALL never drive mem_rd_en in IDLE or DRAIN.

Reset
REQ-027 SHALL, on rst_n low (any time, incl. mid-sweep), return to IDLE, discard buffered/in-flight data and drive busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, m_valid=0, m_last=0, m_vec=0.
REQ-028 SHALL ignore a mem_rd_data return arriving in the first cycle after reset release.

Configuration
REQ-029 SHALL, when macro STATE_READOUT_CLEAR_EN is defined, add ports mem_wr_en (out 1), mem_wr_addr (out S_ADDR_W), mem_wr_data (out TILE_SIZE x W, always 0) and write zero to each address in the cycle after its read is issued (clear-on-read for sequence restart).
REQ-030 SHALL, without STATE_READOUT_CLEAR_EN, omit those ports and leave the RAM unmodified.

Verification
REQ-031 rd_len=4, RAM[i]={i,i+1,i+2,i+3}, m_ready=1 -> 4 consecutive beats addr 0..3, m_last on beat 3, done 1 cycle after, busy 6 cycles.
REQ-032 rd_len=0, S_ADDR_W=6 -> exactly 64 beats, addresses 0..63, m_last only on 64th.
REQ-033 rd_len=8, m_ready toggling 1/0 each cycle -> 8 beats in order, data stable during stalls, mem_rd_en never with occupancy 2.
REQ-034 start pulsed again mid-sweep and rd_len changed to 2 -> ignored; original 8 beats delivered.
REQ-035 rst_n low after 3 beats of rd_len=8 -> all outputs 0 next edge; new start -> sweep restarts at addr 0.
REQ-036 STATE_READOUT_CLEAR_EN defined, rd_len=4 -> mem_wr_en at addrs 0..3 with data 0; second sweep returns all-zero beats.

Source files
------------

// File: rtl/state_readout_vec4.sv
// Sweeps the state RAM from address 0 to len-1 and streams each entry out as an
// AXI-stream beat through a 2-entry skid buffer. Optional clear-on-read: STATE_READOUT_CLEAR_EN.
module state_readout_vec4 #(
  parameter int TILE_SIZE = 4,
  parameter int W         = 16,
  parameter int S_ADDR_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [S_ADDR_W:0]         rd_len,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [S_ADDR_W-1:0]       mem_rd_addr,
  input  logic [TILE_SIZE*W-1:0]    mem_rd_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [TILE_SIZE*W-1:0]    m_vec,
  output logic                      m_last
`ifdef STATE_READOUT_CLEAR_EN
  ,
  output logic                      mem_wr_en,
  output logic [S_ADDR_W-1:0]       mem_wr_addr,
  output logic [TILE_SIZE*W-1:0]    mem_wr_data
`endif
);

  localparam int VW = TILE_SIZE * W;
  localparam int LW = S_ADDR_W + 1;
  localparam logic [LW-1:0] FULL_LEN = LW'(1) << S_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   iss_q;
  logic            infl_q;
  logic            infl_last_q;
  logic [VW-1:0]   buf_vec [2];
  logic            buf_last [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      cnt_q;
  logic            done_q;

  logic            pop;
  logic            head_last;
  logic            issue_last;
  logic [2:0]      occ;
  logic [2:0]      occ_after;
  logic            rd_en;

  assign pop        = (cnt_q != 2'd0) && m_ready;
  assign head_last  = buf_last[rd_ptr_q];
  assign issue_last = (iss_q + LW'(1)) == len_q;
  // Reads in flight count against the buffer so a returning beat always has a slot.
  assign occ        = {1'b0, cnt_q} + 3'(infl_q);
  assign occ_after  = occ - 3'(pop);
  assign rd_en      = (state_q == RUN) && (occ_after < 3'd2);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_en && issue_last) state_d = DRAIN;
      DRAIN:   if (pop && head_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      iss_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      infl_q      <= rd_en;
      infl_last_q <= rd_en && issue_last;
      done_q      <= (state_q == DRAIN) && pop && head_last;
      if (state_q == IDLE && start) begin
        len_q <= (rd_len == '0) ? FULL_LEN : rd_len;
        iss_q <= '0;
      end else if (rd_en) begin
        iss_q <= iss_q + LW'(1);
      end
    end
  end

  // NOTE: the buffer storage is reset because m_vec must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_vec[i]  <= '0;
        buf_last[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (infl_q) begin
        buf_vec[wr_ptr_q]  <= mem_rd_data;
        buf_last[wr_ptr_q] <= infl_last_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(infl_q) - 2'(pop);
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = iss_q[S_ADDR_W-1:0];
  assign m_valid     = (cnt_q != 2'd0);
  assign m_vec       = buf_vec[rd_ptr_q];
  assign m_last      = (cnt_q != 2'd0) && head_last;

`ifdef STATE_READOUT_CLEAR_EN
  // Zero each entry one cycle after it is read so the next sequence starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
    end else begin
      mem_wr_en   <= rd_en;
      mem_wr_addr <= iss_q[S_ADDR_W-1:0];
    end
  end
  assign mem_wr_data = '0;
`endif

endmodule
